// File: rtl/debounced_updown_button_counter.sv
// Up/down push-button LED counter: 2-flop sync, per-button debounce, press edge detect, wrap or saturate step.
// Define AUTO_REPEAT_EN to add hold-to-repeat stepping while exactly one button is held.

module debounced_updown_button_counter #(
    parameter int WIDTH         = 8,
    parameter int DEBOUNCE      = 4,
    parameter int SATURATE      = 0,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_btn_up,
    input  logic             i_btn_down,
    output logic [WIDTH-1:0] o_led,
    output logic             o_up_pulse,
    output logic             o_down_pulse,
    output logic             o_limit_hit
);

    localparam int             CW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0]  DB_LAST = CW'(DEBOUNCE - 1);
    localparam logic [WIDTH-1:0] LED_MAX = '1;

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("WIDTH must be at least 2");
        end
        if (DEBOUNCE < 1) begin : g_bad_debounce
            $error("DEBOUNCE must be at least 1");
        end
        if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
            $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
        end
    endgenerate

    // Bit 0 is the up button, bit 1 the down button throughout.
    logic [1:0]    w_raw;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_lvl;
    logic [1:0]    r_lvl_d;
    logic [CW-1:0] r_db_cnt [2];
    logic [1:0]    w_press;
    logic [1:0]    w_rpt;
    logic [1:0]    w_step;

    logic [WIDTH-1:0] r_led;
    logic             r_up_pulse;
    logic             r_down_pulse;
    logic             r_limit_hit;

    assign w_raw = {i_btn_down, i_btn_up};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_lvl   <= '0;
            r_lvl_d <= '0;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_lvl_d <= r_lvl;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_lvl[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db_cnt[i] <= '0;
                    r_lvl[i]    <= ~r_lvl[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_press = r_lvl & ~r_lvl_d;

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW      = $clog2(RPT_MAX + 1);
    localparam logic [TW-1:0] RPT_DLY_LD = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RPT_PER_LD = TW'(REPEAT_PERIOD - 1);

    logic          w_one_held;
    logic          w_single_press;
    logic          w_rpt_fire;
    logic          r_rpt_act;
    logic [TW-1:0] r_rpt_cnt;

    assign w_one_held     = r_lvl[0] ^ r_lvl[1];
    assign w_single_press = w_press[0] ^ w_press[1];
    assign w_rpt_fire     = r_rpt_act && (r_rpt_cnt == '0) && w_one_held && !w_single_press;

    // Down-counter armed by a lone press; terminal count issues a step and reloads the period.
    always_ff @(posedge i_clk) begin
        if (i_rst || !w_one_held) begin
            r_rpt_act <= 1'b0;
            r_rpt_cnt <= '0;
        end else if (w_single_press) begin
            r_rpt_act <= 1'b1;
            r_rpt_cnt <= RPT_DLY_LD;
        end else if (r_rpt_act) begin
            if (r_rpt_cnt == '0) begin
                r_rpt_cnt <= RPT_PER_LD;
            end else begin
                r_rpt_cnt <= r_rpt_cnt - 1'b1;
            end
        end
    end

    assign w_rpt = {2{w_rpt_fire}} & r_lvl;
`else
    assign w_rpt = 2'b00;
`endif

    assign w_step = w_press | w_rpt;

    // Simultaneous up and down steps cancel: both pulses, count untouched.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_led        <= '0;
            r_up_pulse   <= 1'b0;
            r_down_pulse <= 1'b0;
            r_limit_hit  <= 1'b0;
        end else begin
            r_up_pulse   <= w_step[0];
            r_down_pulse <= w_step[1];
            r_limit_hit  <= 1'b0;
            if (w_step == 2'b01) begin
                if (r_led == LED_MAX) begin
                    r_limit_hit <= 1'b1;
                    if (SATURATE == 0) begin
                        r_led <= '0;
                    end
                end else begin
                    r_led <= r_led + 1'b1;
                end
            end else if (w_step == 2'b10) begin
                if (r_led == '0) begin
                    r_limit_hit <= 1'b1;
                    if (SATURATE == 0) begin
                        r_led <= LED_MAX;
                    end
                end else begin
                    r_led <= r_led - 1'b1;
                end
            end
        end
    end

    assign o_led        = r_led;
    assign o_up_pulse   = r_up_pulse;
    assign o_down_pulse = r_down_pulse;
    assign o_limit_hit  = r_limit_hit;

endmodule

// File: tb/tb_debounced_updown_button_counter.sv
// Bench for debounced_updown_button_counter: wrapping and saturating instances share stimulus,
// every edge is compared against a history-window reference model.

module tb_debounced_updown_button_counter;

    localparam int W    = 4;
    localparam int D    = 4;
    localparam int RD   = 8;
    localparam int RP   = 4;
    localparam int MAXV = (1 << W) - 1;
    localparam int HN   = 8192;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         btn_up = 1'b0;
    logic         btn_down = 1'b0;
    logic [W-1:0] led0, led1;
    logic         up0, dn0, lim0, up1, dn1, lim1;

    always #5 clk = ~clk;

    debounced_updown_button_counter #(
        .WIDTH(W), .DEBOUNCE(D), .SATURATE(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_btn_up(btn_up), .i_btn_down(btn_down),
        .o_led(led0), .o_up_pulse(up0), .o_down_pulse(dn0), .o_limit_hit(lim0)
    );

    debounced_updown_button_counter #(
        .WIDTH(W), .DEBOUNCE(D), .SATURATE(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_btn_up(btn_up), .i_btn_down(btn_down),
        .o_led(led1), .o_up_pulse(up1), .o_down_pulse(dn1), .o_limit_hit(lim1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: raw input and debounced level history, indexed by edge number.
    bit h_up [HN];
    bit h_dn [HN];
    bit l_up [HN];
    bit l_dn [HN];
    bit p_up [HN];
    bit p_dn [HN];
    int e_now = 0;
    int r_last = 0;
    int f_up = 0;
    int f_dn = 0;
    int rp = 0;
    bit rp_valid = 1'b0;
    int m_led0 = 0;
    int m_led1 = 0;
    bit m_upp = 1'b0;
    bit m_dnp = 1'b0;
    bit m_lim0 = 1'b0;
    bit m_lim1 = 1'b0;

    typedef struct {
        bit r;
        bit u;
        bit d;
        int n;
        int led0;
        int led1;
        int upc;
        int dnc;
        int lim0c;
        int lim1c;
    } seg_t;

    seg_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, e_now, act, exp);
        end
    endtask

    // Synchronised value visible after edge k: the raw value sampled one edge earlier.
    function automatic bit sync2(input bit is_up, input int k);
        if (k - 1 <= r_last) return 1'b0;
        return is_up ? h_up[k-1] : h_dn[k-1];
    endfunction

    // Level flips once the synced input has disagreed with it for the last D cycles since its last flip.
    function automatic bit new_lvl(input bit is_up, input int e, input int lf);
        bit prev;
        prev = is_up ? l_up[e-1] : l_dn[e-1];
        if (e - lf < D) return prev;
        for (int j = e - D; j < e; j++) begin
            if (sync2(is_up, j) == prev) return prev;
        end
        return !prev;
    endfunction

    task automatic model_edge(input int e, input bit r, input bit u, input bit d);
        bit nu, nd, su, sd;
`ifdef AUTO_REPEAT_EN
        bit oh, rep;
`endif
        h_up[e] = u;
        h_dn[e] = d;
        if (r) begin
            r_last = e; f_up = e; f_dn = e;
            l_up[e] = 1'b0; l_dn[e] = 1'b0; p_up[e] = 1'b0; p_dn[e] = 1'b0;
            rp_valid = 1'b0;
            m_led0 = 0; m_led1 = 0;
            m_upp = 1'b0; m_dnp = 1'b0; m_lim0 = 1'b0; m_lim1 = 1'b0;
            return;
        end
        nu = new_lvl(1'b1, e, f_up);
        nd = new_lvl(1'b0, e, f_dn);
        if (nu != l_up[e-1]) f_up = e;
        if (nd != l_dn[e-1]) f_dn = e;
        l_up[e] = nu;
        l_dn[e] = nd;
        p_up[e] = nu && !l_up[e-1];
        p_dn[e] = nd && !l_dn[e-1];
        su = p_up[e-1];
        sd = p_dn[e-1];
`ifdef AUTO_REPEAT_EN
        oh  = l_up[e-1] ^ l_dn[e-1];
        rep = rp_valid && oh && (e - rp >= RD) && (((e - rp - RD) % RP) == 0);
        if (rep) begin
            if (l_up[e-1]) su = 1'b1;
            else sd = 1'b1;
        end
        if (!oh) rp_valid = 1'b0;
        else if (p_up[e-1] ^ p_dn[e-1]) begin
            rp_valid = 1'b1;
            rp = e;
        end
`endif
        m_upp = su; m_dnp = sd; m_lim0 = 1'b0; m_lim1 = 1'b0;
        if (su && !sd) begin
            if (m_led0 == MAXV) begin m_led0 = 0; m_lim0 = 1'b1; end
            else m_led0 = m_led0 + 1;
            if (m_led1 == MAXV) m_lim1 = 1'b1;
            else m_led1 = m_led1 + 1;
        end else if (sd && !su) begin
            if (m_led0 == 0) begin m_led0 = MAXV; m_lim0 = 1'b1; end
            else m_led0 = m_led0 - 1;
            if (m_led1 == 0) m_lim1 = 1'b1;
            else m_led1 = m_led1 - 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        e_now++;
        if (e_now >= HN) begin
            $display("FAIL edge_budget: reached edge %0d, limit %0d", e_now, HN);
            $fatal(1);
        end
        model_edge(e_now, rst, btn_up, btn_down);
        #1;
        chk("model_led0", int'(led0), m_led0);
        chk("model_led1", int'(led1), m_led1);
        chk("model_up0", int'(up0), int'(m_upp));
        chk("model_dn0", int'(dn0), int'(m_dnp));
        chk("model_up1", int'(up1), int'(m_upp));
        chk("model_dn1", int'(dn1), int'(m_dnp));
        chk("model_lim0", int'(lim0), int'(m_lim0));
        chk("model_lim1", int'(lim1), int'(m_lim1));
    endtask

    function automatic seg_t mk(input bit r, input bit u, input bit d, input int n,
                                input int a0, input int a1, input int uc, input int dc,
                                input int l0, input int l1);
        seg_t s;
        s.r = r; s.u = u; s.d = d; s.n = n;
        s.led0 = a0; s.led1 = a1; s.upc = uc; s.dnc = dc; s.lim0c = l0; s.lim1c = l1;
        return s;
    endfunction

    initial begin
        int cu, cd, cl0, cl1, ru, rdn;
        int q_edges[$];
        int exp_edges[$];
        int a_exp;

        // Reset, idle, glitch train, 16 wrapping ups, limit and simultaneous-press cases.
        tbl.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 20, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 16; i++) begin
            tbl.push_back(mk(0, 1, 0, 8, i % 16, (i < 15) ? i : 15, 1, 0,
                             int'(i == 16), int'(i == 16)));
            tbl.push_back(mk(0, 0, 0, 8, i % 16, (i < 15) ? i : 15, 0, 0, 0, 0));
        end
        tbl.push_back(mk(0, 0, 1, 8, 15, 14, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8, 15, 14, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8, 15, 14, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8, 15, 14, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8, 0, 15, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8, 0, 15, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8, 1, 15, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8, 1, 15, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8, 0, 14, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8, 0, 14, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8, 15, 13, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8, 15, 13, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r; btn_up = tbl[i].u; btn_down = tbl[i].d;
            cu = 0; cd = 0; cl0 = 0; cl1 = 0;
            for (int k = 0; k < tbl[i].n; k++) begin
                step();
                cu += int'(up0); cd += int'(dn0); cl0 += int'(lim0); cl1 += int'(lim1);
            end
            chk($sformatf("seg%0d_led0", i), int'(led0), tbl[i].led0);
            chk($sformatf("seg%0d_led1", i), int'(led1), tbl[i].led1);
            chk($sformatf("seg%0d_up_pulses", i), cu, tbl[i].upc);
            chk($sformatf("seg%0d_down_pulses", i), cd, tbl[i].dnc);
            chk($sformatf("seg%0d_limit0", i), cl0, tbl[i].lim0c);
            chk($sformatf("seg%0d_limit1", i), cl1, tbl[i].lim1c);
        end

        // Press latency: held from first edge after reset, step lands on edge 7.
        rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
        step(); step();
        rst = 1'b0; btn_up = 1'b1;
        cu = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            cu += int'(up0);
            if (k <= 8) begin
                chk("latency_led", int'(led0), int'(k >= 7));
                chk("latency_up_pulse", int'(up0), int'(k == 7));
            end
        end
        btn_up = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            cu += int'(up0);
        end
`ifdef AUTO_REPEAT_EN
        a_exp = 4;
`else
        a_exp = 1;
`endif
        chk("hold20_up_pulses", cu, a_exp);
        chk("hold20_led", int'(led0), a_exp);

        // Reset while a press is in progress at led=5.
        rst = 1'b1; step(); step(); rst = 1'b0;
        for (int p = 0; p < 5; p++) begin
            btn_up = 1'b1;
            repeat (8) step();
            btn_up = 1'b0;
            repeat (8) step();
        end
        chk("midrst_led_before", int'(led0), 5);
        btn_up = 1'b1;
        repeat (3) step();
        chk("midrst_led_held", int'(led0), 5);
        rst = 1'b1;
        step(); step();
        chk("midrst_led0_in_reset", int'(led0), 0);
        chk("midrst_led1_in_reset", int'(led1), 0);
        chk("midrst_up_in_reset", int'(up0), 0);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("midrst_led_after", int'(led0), int'(k >= 7));
            chk("midrst_up_after", int'(up0), int'(k == 7));
        end
        btn_up = 1'b0;
        repeat (16) step();

        // Long hold: debounced release lands on edge 30 after the 24-edge raw hold.
        rst = 1'b1; step(); step(); rst = 1'b0;
        btn_up = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 25) btn_up = 1'b0;
            step();
            if (up0) q_edges.push_back(k);
        end
`ifdef AUTO_REPEAT_EN
        exp_edges = '{7, 15, 19, 23, 27};
`else
        exp_edges = '{7};
`endif
        chk("hold_step_count", q_edges.size(), exp_edges.size());
        for (int i = 0; i < exp_edges.size(); i++) begin
            chk($sformatf("hold_step%0d_edge", i), (i < q_edges.size()) ? q_edges[i] : -1, exp_edges[i]);
        end
        chk("hold_final_led", int'(led0), exp_edges.size());

        // Random bursty buttons with occasional resets, checked edge by edge against the model.
        ru = 0; rdn = 0;
        for (int n = 0; n < 2500; n++) begin
            if (ru == 0) begin
                btn_up = ($urandom_range(0, 1) == 1);
                ru = int'($urandom_range(1, 14));
            end
            if (rdn == 0) begin
                btn_down = ($urandom_range(0, 1) == 1);
                rdn = int'($urandom_range(1, 14));
            end
            ru--; rdn--;
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
